div_fp_stream: RTL and testbench
================================

Name: div_fp_stream

Overview:
- Signed fixed-point divider with valid/ready streaming handshakes on input and output, plus a pass-through tag.
- Serves as the next-generation divider for the pipeline math path, e.g. perspective divide and normalisation.
- Generalises the existing iterative radix-2 divider:
  - the full signed range is legal, including the most negative value;
  - rounding mode is selectable;
  - overflow and divide-by-zero can saturate;
  - latency is fixed and deterministic;
  - the output register holds under backpressure.

Parameters:
- WIDTH, 16: total operand/result width in bits, two's complement; legal range 4..32.
- FBITS, 8: fractional bits within WIDTH; legal range 0..WIDTH-1.
- ROUND_MODE, 1: 0 = truncate toward zero; 1 = round half to even; 2 = round half away from zero.
- SAT, 1: 1 = saturate result on ovf/dbz; 0 = result forced to 0 on ovf/dbz.
- TAG_W, 4: width of the user tag carried alongside each operation; must be ≥1.

Ports:
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  divider can accept an operand pair
- a  in  WIDTH  signed dividend
- b  in  WIDTH  signed divisor
- in_tag  in  TAG_W  user tag, captured with the operands
- out_valid  out  1  result valid; held until accepted
- out_ready  in  1  downstream accepts the result
- val  out  WIDTH  signed quotient
- out_tag  out  TAG_W  tag of the operation that produced val
- ovf  out  1  result out of range; qualified by out_valid
- dbz  out  1  b was zero; qualified by out_valid

Behaviour:
- Reset:
  - rst_n low forces state IDLE, in_ready=0 while rst_n is low, out_valid=0, val=0, out_tag=0, ovf=0, dbz=0, and iteration counter=0.
  - Assertion mid-operation discards the operation; no result is emitted.
  - in_ready rises in the first cycle after rst_n deasserts.
- Handshakes:
  - An input transfer occurs when in_valid && in_ready at a rising edge (cycle t0).
  - An output transfer occurs when out_valid && out_ready.
  - in_ready = (state==IDLE) && !out_valid. At most one operation is in flight; there is no same-cycle accept-after-drain.
  - While out_valid=1 and out_ready=0, val, out_tag, ovf and dbz are stable.
- States: IDLE, CALC, ROUND, SIGN, HOLD.
- IDLE, on accept:
  - Register |a| and |b| as WIDTH-bit unsigned; |-2^(WIDTH-1)| = 2^(WIDTH-1) is representable.
  - Register sign_diff = a[msb]^b[msb], tag, and sign of a.
  - If b==0, go to HOLD with dbz=1, ovf=0, so out_valid=1 at t0+1. val = SAT ? (a>0 ? max : a<0 ? min : 0) : 0.
  - Otherwise go to CALC with acc=0, quo=|a|<<FBITS, held in a QW=WIDTH+FBITS bit register, counter=0.
- CALC:
  - Restoring division, one quotient bit per cycle, QW cycles.
  - Each cycle: acc' = {acc,quo msb}; if acc' ≥ |b| then subtract and shift in 1, else shift in 0.
  - acc is WIDTH+1 bits. The counter is $clog2(QW+1) bits.
  - Exits to ROUND after iteration QW-1; the magnitude q = floor(|a|·2^FBITS/|b|) is then exact.
- ROUND: guard = (2·rem ≥ |b|); sticky = (2·rem ≠ |b|).
  - Mode 0: no change.
  - Mode 1: q += guard && (sticky || q[0]).
  - Mode 2: q += guard.
  - q is one bit wider internally so the increment never wraps.
- SIGN:
  - Limit = 2^(WIDTH-1) if sign_diff, else 2^(WIDTH-1)-1.
  - If q > limit: ovf=1 and val = SAT ? (sign_diff ? min : max) : 0.
  - Else val = sign_diff ? -q : q. A zero quotient is always +0.
  - dbz=0. Go to HOLD with out_valid=1.
- Timing: non-dbz results have out_valid first high at cycle t0+QW+2 regardless of operand values.
- HOLD: on output transfer, out_valid=0 and go to IDLE. in_ready returns high the next cycle.
- Range terms: max = 2^(WIDTH-1)-1 and min = -2^(WIDTH-1), both as raw codes.
- Inputs a, b and in_tag are sampled only on the accept edge. Changes at other times are ignored.

Test Plan (WIDTH=8, FBITS=4, TAG_W=4 unless stated):
- a=0x30 (3.0), b=0x20 (2.0), tag=5, out_ready=1 -> val=0x18, out_tag=5, ovf=0, dbz=0, out_valid first high at t0+14.
- a=0xF0 (-1.0), b=0x30 (3.0) -> val=0xFB (-0.3125) in every ROUND_MODE; a=0x10, b=0x30 -> val=0x05.
- a=0x01, b=0x20 (exact half LSB) -> ROUND_MODE 0 gives 0x00, mode 1 gives 0x00, mode 2 gives 0x01. a=0x03, b=0x20 -> mode 1 gives 0x02.
- Range edges:
  - a=0x80, b=0x10 -> val=0x80, ovf=0.
  - a=0x80, b=0xF0 -> ovf=1, val=0x7F (SAT=1) or 0x00 (SAT=0).
  - a=0x70, b=0x08 -> ovf=1, val=0x7F.
- b=0:
  - a=0x20 -> dbz=1, val=0x7F, out_valid at t0+1.
  - a=0xE0 -> val=0x80.
  - a=0 -> val=0x00.
  - SAT=0 -> val=0x00 in all three cases.
- Backpressure and reset:
  - Hold out_ready=0 for 10 cycles with in_valid=1 and new operands: outputs stable, in_ready=0, second operation accepted only after the drain.
  - Pulse rst_n low during CALC: all outputs cleared immediately, no stale out_valid afterwards.

Source files
------------

// File: rtl/div_fp_stream.sv
// Signed fixed-point restoring divider with valid/ready streaming, selectable
// rounding, optional saturation and a deterministic WIDTH+FBITS+2 cycle latency.
module div_fp_stream #(
  parameter int WIDTH      = 16,
  parameter int FBITS      = 8,
  parameter int ROUND_MODE = 1,
  parameter int SAT        = 1,
  parameter int TAG_W      = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] val,
  output logic [TAG_W-1:0] out_tag,
  output logic             ovf,
  output logic             dbz
);

  localparam int QW = WIDTH + FBITS;
  localparam int CW = $clog2(QW + 1);
  localparam logic [WIDTH-1:0] MAXV = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MINV = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [QW:0] LIM_POS = (QW+1)'(MAXV);
  localparam logic [QW:0] LIM_NEG = LIM_POS + (QW+1)'(1);

  typedef enum logic [2:0] {S_IDLE, S_CALC, S_ROUND, S_SIGN, S_HOLD} state_t;

  state_t             state_q;
  logic               rdy_q;
  logic               sdiff_q;
  logic [WIDTH-1:0]   bmag_q;
  logic [WIDTH:0]     acc_q;
  logic [QW-1:0]      quo_q;
  logic [QW:0]        q_q;
  logic [CW-1:0]      cnt_q;
  logic [TAG_W-1:0]   tag_q;
  logic               out_valid_q, ovf_q, dbz_q;
  logic [WIDTH-1:0]   val_q;
  logic [TAG_W-1:0]   out_tag_q;

  // Magnitudes: the most negative code negates onto itself, which read as
  // unsigned is exactly 2^(WIDTH-1).
  logic [WIDTH-1:0] amag, bmag, dbz_val;
  assign amag = a[WIDTH-1] ? (~a + WIDTH'(1)) : a;
  assign bmag = b[WIDTH-1] ? (~b + WIDTH'(1)) : b;
  assign dbz_val = a[WIDTH-1] ? MINV : ((|a) ? MAXV : '0);

  logic [WIDTH:0] acc_sh, acc_nx;
  logic           take;
  assign acc_sh = {acc_q[WIDTH-1:0], quo_q[QW-1]};
  assign take   = acc_sh >= {1'b0, bmag_q};
  assign acc_nx = take ? (acc_sh - {1'b0, bmag_q}) : acc_sh;

  logic [WIDTH+1:0] rem2, bx;
  logic             guard, sticky, inc;
  assign rem2   = {acc_q, 1'b0};
  assign bx     = {2'b00, bmag_q};
  assign guard  = rem2 >= bx;
  assign sticky = rem2 != bx;

  always_comb begin
    inc = 1'b0;
    case (ROUND_MODE)
      1:       inc = guard && (sticky || quo_q[0]);
      2:       inc = guard;
      default: inc = 1'b0;
    endcase
  end

  logic [QW:0]      q_rnd, limit;
  logic [WIDTH-1:0] q_lo, q_neg;
  assign q_rnd = {1'b0, quo_q} + (QW+1)'(inc);
  assign limit = sdiff_q ? LIM_NEG : LIM_POS;
  assign q_lo  = q_q[WIDTH-1:0];
  assign q_neg = ~q_lo + WIDTH'(1);

  assign in_ready  = rdy_q && (state_q == S_IDLE) && !out_valid_q;
  assign out_valid = out_valid_q;
  assign val       = val_q;
  assign out_tag   = out_tag_q;
  assign ovf       = ovf_q;
  assign dbz       = dbz_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      rdy_q       <= 1'b0;
      sdiff_q     <= 1'b0;
      bmag_q      <= '0;
      acc_q       <= '0;
      quo_q       <= '0;
      q_q         <= '0;
      cnt_q       <= '0;
      tag_q       <= '0;
      out_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
      dbz_q       <= 1'b0;
      val_q       <= '0;
      out_tag_q   <= '0;
    end else begin
      rdy_q <= 1'b1;
      case (state_q)
        S_IDLE: if (in_valid && in_ready) begin
          bmag_q  <= bmag;
          sdiff_q <= a[WIDTH-1] ^ b[WIDTH-1];
          tag_q   <= in_tag;
          acc_q   <= '0;
          quo_q   <= QW'(amag) << FBITS;
          cnt_q   <= '0;
          if (b == '0) begin
            state_q     <= S_HOLD;
            out_valid_q <= 1'b1;
            dbz_q       <= 1'b1;
            ovf_q       <= 1'b0;
            val_q       <= (SAT != 0) ? dbz_val : '0;
            out_tag_q   <= in_tag;
          end else begin
            state_q <= S_CALC;
          end
        end
        S_CALC: begin
          acc_q <= acc_nx;
          quo_q <= {quo_q[QW-2:0], take};
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CW'(QW - 1)) state_q <= S_ROUND;
        end
        S_ROUND: begin
          q_q     <= q_rnd;
          state_q <= S_SIGN;
        end
        S_SIGN: begin
          out_valid_q <= 1'b1;
          out_tag_q   <= tag_q;
          dbz_q       <= 1'b0;
          state_q     <= S_HOLD;
          if (q_q > limit) begin
            ovf_q <= 1'b1;
            val_q <= (SAT != 0) ? (sdiff_q ? MINV : MAXV) : '0;
          end else begin
            ovf_q <= 1'b0;
            val_q <= sdiff_q ? q_neg : q_lo;
          end
        end
        S_HOLD: if (out_ready) begin
          out_valid_q <= 1'b0;
          state_q     <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_fp_stream.sv
// Four dividers (rounding modes 0/1/2 saturating, mode 1 non-saturating) driven
// in lockstep from a directed vector table, hand sequences and random operands.
module tb_div_fp_stream;
  localparam int N = 4;

  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [7:0] a = '0, b = '0;
  logic [3:0] in_tag = '0;
  logic [N-1:0]      in_rdy, ovld, ovf_v, dbz_v;
  logic [N-1:0][7:0] val_v;
  logic [N-1:0][3:0] tag_v;
  int errs = 0, checks = 0;

  for (genvar g = 0; g < N; g++) begin : g_dut
    div_fp_stream #(.WIDTH(8), .FBITS(4), .ROUND_MODE(g == 3 ? 1 : g),
                    .SAT(g == 3 ? 0 : 1), .TAG_W(4)) u_dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_rdy[g]),
      .a(a), .b(b), .in_tag(in_tag), .out_valid(ovld[g]), .out_ready(out_ready),
      .val(val_v[g]), .out_tag(tag_v[g]), .ovf(ovf_v[g]), .dbz(dbz_v[g]));
  end

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Exact-arithmetic reference: quotient magnitude from integer division,
  // rounding decided from the remainder, range test on the signed result.
  function automatic logic [7:0] mval(input logic [7:0] ia, input logic [7:0] ib,
                                      input int mode, input bit sat,
                                      output bit eovf, output bit edbz);
    int sa, sb, na, nb, q, r, res;
    sa = int'($signed(ia));
    sb = int'($signed(ib));
    eovf = 1'b0;
    edbz = (sb == 0);
    if (edbz) return !sat ? 8'h00 : (sa > 0 ? 8'h7F : (sa < 0 ? 8'h80 : 8'h00));
    na = (sa < 0 ? -sa : sa) * 16;
    nb = (sb < 0 ? -sb : sb);
    q = na / nb;
    r = na % nb;
    if (mode == 1 && (2*r > nb || (2*r == nb && q % 2 == 1))) q++;
    if (mode == 2 && 2*r >= nb) q++;
    res = ((sa < 0) != (sb < 0)) ? -q : q;
    if (res > 127 || res < -128) begin
      eovf = 1'b1;
      return !sat ? 8'h00 : (res > 0 ? 8'h7F : 8'h80);
    end
    return res[7:0];
  endfunction

  // Leaves the bench on the negedge following the accept edge.
  task automatic accept(input logic [7:0] ia, input logic [7:0] ib, input logic [3:0] it);
    int n = 0;
    @(negedge clk);
    in_valid = 1'b1; a = ia; b = ib; in_tag = it;
    while (!(&in_rdy) && n < 100) begin @(negedge clk); n++; end
    chk("accept_wait", 32'(n < 100), 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; a = 8'($urandom); b = 8'($urandom); in_tag = 4'($urandom);
  endtask

  // Edges after the accept edge at which out_valid was first registered.
  task automatic wait_out(output int lat);
    lat = 0;
    while (!(&ovld) && lat < 100) begin @(negedge clk); lat++; end
  endtask

  task automatic check_model(input string name, input logic [7:0] ia, input logic [7:0] ib,
                             input logic [3:0] it);
    bit eo, ed;
    logic [7:0] ev;
    for (int g = 0; g < N; g++) begin
      ev = mval(ia, ib, (g == 3) ? 1 : g, g != 3, eo, ed);
      chk($sformatf("%s a=%h b=%h u%0d val/ovf/dbz/tag", name, ia, ib, g),
          {val_v[g], ovf_v[g], dbz_v[g], tag_v[g]}, {ev, eo, ed, it});
    end
  endtask

  task automatic drain();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("drain_out_valid", 32'(ovld), 32'd0);
    chk("drain_in_ready", 32'(in_rdy), 32'hF);
  endtask

  typedef struct {
    logic [7:0]        a, b;
    logic [N-1:0][7:0] v;   // {sat0_m1, m2, m1, m0}
    logic              ovf, dbz;
  } vec_t;

  vec_t tbl[11];

  initial begin
    int lat;
    logic [31:0] snap;
    int diffs, rdy_seen, vld_seen;
    logic [7:0] ra, rb;
    logic [3:0] rt;

    tbl[0]  = '{8'h30, 8'h20, {8'h18, 8'h18, 8'h18, 8'h18}, 1'b0, 1'b0};
    tbl[1]  = '{8'hF0, 8'h30, {8'hFB, 8'hFB, 8'hFB, 8'hFB}, 1'b0, 1'b0};
    tbl[2]  = '{8'h10, 8'h30, {8'h05, 8'h05, 8'h05, 8'h05}, 1'b0, 1'b0};
    tbl[3]  = '{8'h01, 8'h20, {8'h00, 8'h01, 8'h00, 8'h00}, 1'b0, 1'b0};
    tbl[4]  = '{8'h03, 8'h20, {8'h02, 8'h02, 8'h02, 8'h01}, 1'b0, 1'b0};
    tbl[5]  = '{8'h80, 8'h10, {8'h80, 8'h80, 8'h80, 8'h80}, 1'b0, 1'b0};
    tbl[6]  = '{8'h80, 8'hF0, {8'h00, 8'h7F, 8'h7F, 8'h7F}, 1'b1, 1'b0};
    tbl[7]  = '{8'h70, 8'h08, {8'h00, 8'h7F, 8'h7F, 8'h7F}, 1'b1, 1'b0};
    tbl[8]  = '{8'h20, 8'h00, {8'h00, 8'h7F, 8'h7F, 8'h7F}, 1'b0, 1'b1};
    tbl[9]  = '{8'hE0, 8'h00, {8'h00, 8'h80, 8'h80, 8'h80}, 1'b0, 1'b1};
    tbl[10] = '{8'h00, 8'h00, {8'h00, 8'h00, 8'h00, 8'h00}, 1'b0, 1'b1};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 32'(in_rdy), 32'd0);
    chk("rst_outputs", {ovld, ovf_v, dbz_v, val_v[0], tag_v[0]}, 32'd0);
    chk("rst_val_all", 32'(val_v), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("rst_release_in_ready", 32'(in_rdy), 32'd0);
    @(negedge clk);
    chk("post_rst_in_ready", 32'(in_rdy), 32'hF);

    // Directed table
    for (int i = 0; i < 11; i++) begin
      accept(tbl[i].a, tbl[i].b, 4'(i + 1));
      wait_out(lat);
      chk($sformatf("vec%0d latency", i), 32'(lat), tbl[i].dbz ? 32'd0 : 32'd14);
      for (int g = 0; g < N; g++)
        chk($sformatf("vec%0d u%0d val", i, g), 32'(val_v[g]), 32'(tbl[i].v[g]));
      chk($sformatf("vec%0d ovf/dbz", i), {ovf_v, dbz_v}, {{N{tbl[i].ovf}}, {N{tbl[i].dbz}}});
      chk($sformatf("vec%0d tag", i), 32'(tag_v), {N{4'(i + 1)}});
      chk($sformatf("vec%0d hold_in_ready", i), 32'(in_rdy), 32'd0);
      drain();
    end

    // Backpressure with a second operation waiting at the input
    accept(8'h30, 8'h20, 4'd5);
    wait_out(lat);
    in_valid = 1'b1; a = 8'h10; b = 8'h30; in_tag = 4'd9;
    snap = {val_v[0], val_v[3], ovf_v, dbz_v, tag_v[0]};
    diffs = 0; rdy_seen = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if ({val_v[0], val_v[3], ovf_v, dbz_v, tag_v[0]} !== snap || !(&ovld)) diffs++;
      if (|in_rdy) rdy_seen++;
    end
    chk("bp_outputs_stable", 32'(diffs), 32'd0);
    chk("bp_in_ready_low", 32'(rdy_seen), 32'd0);
    check_model("bp_first", 8'h30, 8'h20, 4'd5);
    drain();
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    wait_out(lat);
    chk("bp_second_latency", 32'(lat), 32'd14);
    check_model("bp_second", 8'h10, 8'h30, 4'd9);
    drain();

    // Reset in the middle of CALC
    accept(8'h70, 8'h30, 4'd7);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_outputs", {ovld, in_rdy, ovf_v, dbz_v, tag_v[1]}, 32'd0);
    chk("midrst_val", 32'(val_v), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    vld_seen = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (|ovld) vld_seen++;
    end
    chk("midrst_no_stale_valid", 32'(vld_seen), 32'd0);
    chk("midrst_in_ready", 32'(in_rdy), 32'hF);

    // Random operands against the reference model
    for (int i = 0; i < 200; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); rt = 4'($urandom);
      case ($urandom_range(0, 9))
        0: rb = 8'h00;
        1: ra = 8'h80;
        2: rb = (i % 3 == 0) ? 8'h01 : ((i % 3 == 1) ? 8'hFF : 8'h80);
        3: ra = 8'h00;
        default: ;
      endcase
      accept(ra, rb, rt);
      wait_out(lat);
      chk($sformatf("rnd%0d latency", i), 32'(lat), (rb == 8'h00) ? 32'd0 : 32'd14);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      check_model($sformatf("rnd%0d", i), ra, rb, rt);
      drain();
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
